// File: rtl/diverge_ctrl.sv
// Leaf-side receive controller: splits the BFT stream into data writes and freespace updates.
// Blocked data waits in an in-order hold buffer while resend throttles upstream.
module diverge_ctrl #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7,
  parameter int HOLD_DEPTH    = 4
) (
  input  logic                     clk_bft,
  input  logic                     reset_bft,
  input  logic [PACKET_BITS-1:0]   stream_in,
  input  logic [NUM_IN_PORTS-1:0]  in_full,
  output logic [PACKET_BITS-1:0]   in_packet,
  output logic [NUM_IN_PORTS-1:0]  in_wr_en,
  output logic [PACKET_BITS-1:0]   update_packet,
  output logic [NUM_OUT_PORTS-1:0] update_valid,
  output logic                     resend,
  output logic                     overflow_err,
  output logic                     bad_port_err
);

  localparam int PTR_W = $clog2(HOLD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(HOLD_DEPTH);

  logic [PACKET_BITS-1:0] r_mem [HOLD_DEPTH];
  logic [PTR_W-1:0]       r_rdPtr;
  logic [PTR_W-1:0]       r_wrPtr;
  logic [CNT_W-1:0]       r_count;

  logic                     w_inValid;
  logic                     w_inIsUpd;
  logic [NUM_PORT_BITS-1:0] w_inPort;
  logic [PACKET_BITS-1:0]   w_head;
  logic [NUM_PORT_BITS-1:0] w_headPort;
  logic                     w_headFull;
  logic                     w_inFull;
  logic [NUM_IN_PORTS-1:0]  w_inOneHot;
  logic [NUM_IN_PORTS-1:0]  w_headOneHot;
  logic [NUM_OUT_PORTS-1:0] w_updOneHot;
  logic                     w_dataArr;
  logic                     w_dataBad;
  logic                     w_updOk;
  logic                     w_updBad;
  logic                     w_deq;
  logic                     w_direct;
  logic                     w_enqReq;
  logic                     w_drop;
  logic                     w_enq;
  logic [CNT_W-1:0]         w_countNext;

  assign w_inValid  = stream_in[PACKET_BITS-1];
  assign w_inIsUpd  = stream_in[PACKET_BITS-2];
  assign w_inPort   = stream_in[PACKET_BITS-3 -: NUM_PORT_BITS];
  assign w_head     = r_mem[r_rdPtr];
  assign w_headPort = w_head[PACKET_BITS-3 -: NUM_PORT_BITS];

  // Port decoding by comparison keeps out-of-range indices from ever selecting a bit.
  always_comb begin
    w_headFull   = 1'b0;
    w_inFull     = 1'b0;
    w_inOneHot   = '0;
    w_headOneHot = '0;
    w_updOneHot  = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (w_headPort == NUM_PORT_BITS'(i)) begin
        w_headFull      = in_full[i];
        w_headOneHot[i] = 1'b1;
      end
      if (w_inPort == NUM_PORT_BITS'(i)) begin
        w_inFull      = in_full[i];
        w_inOneHot[i] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      if (w_inPort == NUM_PORT_BITS'(j)) begin
        w_updOneHot[j] = 1'b1;
      end
    end
  end

  // The head always wins the single write slot; a new arrival goes direct only when nothing is queued.
  always_comb begin
    w_dataArr   = w_inValid && !w_inIsUpd && (int'(w_inPort) < NUM_IN_PORTS);
    w_dataBad   = w_inValid && !w_inIsUpd && (int'(w_inPort) >= NUM_IN_PORTS);
    w_updOk     = w_inValid && w_inIsUpd && (int'(w_inPort) < NUM_OUT_PORTS);
    w_updBad    = w_inValid && w_inIsUpd && (int'(w_inPort) >= NUM_OUT_PORTS);
    w_deq       = (r_count != '0) && !w_headFull;
    w_direct    = w_dataArr && (r_count == '0) && !w_inFull;
    w_enqReq    = w_dataArr && !w_direct;
    w_drop      = w_enqReq && (r_count == LP_FULL) && !w_deq;
    w_enq       = w_enqReq && !w_drop;
    w_countNext = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
  end

  always_ff @(posedge clk_bft) begin
    if (w_enq) begin
      r_mem[r_wrPtr] <= stream_in;
    end
  end

  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
      r_count       <= '0;
      in_packet     <= '0;
      in_wr_en      <= '0;
      update_packet <= '0;
      update_valid  <= '0;
      resend        <= 1'b0;
      overflow_err  <= 1'b0;
      bad_port_err  <= 1'b0;
    end else begin
      in_wr_en <= '0;
      if (w_deq) begin
        in_wr_en  <= w_headOneHot;
        in_packet <= w_head;
      end else if (w_direct) begin
        in_wr_en  <= w_inOneHot;
        in_packet <= stream_in;
      end
      update_valid <= w_updOk ? w_updOneHot : '0;
      if (w_updOk) begin
        update_packet <= stream_in;
      end
      if (w_deq) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_enq) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      r_count <= w_countNext;
      resend  <= (w_countNext != '0);
      if (w_drop) begin
        overflow_err <= 1'b1;
      end
      if (w_dataBad || w_updBad) begin
        bad_port_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_diverge_ctrl.sv
// Bench for diverge_ctrl: directed scenarios plus random traffic, all cycles checked
// against a queue-based reference model of the receive controller.
module tb_diverge_ctrl;

  localparam int PB   = 97;
  localparam int NIN  = 7;
  localparam int NOUT = 7;
  localparam int HD   = 4;

  logic            clk_bft = 1'b0;
  logic            reset_bft;
  logic [PB-1:0]   stream_in;
  logic [NIN-1:0]  in_full;
  logic [PB-1:0]   in_packet;
  logic [NIN-1:0]  in_wr_en;
  logic [PB-1:0]   update_packet;
  logic [NOUT-1:0] update_valid;
  logic            resend;
  logic            overflow_err;
  logic            bad_port_err;

  diverge_ctrl dut (
    .clk_bft(clk_bft),
    .reset_bft(reset_bft),
    .stream_in(stream_in),
    .in_full(in_full),
    .in_packet(in_packet),
    .in_wr_en(in_wr_en),
    .update_packet(update_packet),
    .update_valid(update_valid),
    .resend(resend),
    .overflow_err(overflow_err),
    .bad_port_err(bad_port_err)
  );

  always #5 clk_bft = ~clk_bft;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: expected registered outputs and the pending data packets in order.
  logic [PB-1:0]   expInPkt;
  logic [NIN-1:0]  expInWr;
  logic [PB-1:0]   expUpdPkt;
  logic [NOUT-1:0] expUpdValid;
  logic            expResend;
  logic            expOvf;
  logic            expBad;
  logic [PB-1:0]   holdQ[$];

  task automatic checkOutput(input string tag, input logic [PB-1:0] observed, input logic [PB-1:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [PB-1:0] makePkt(input logic v, input logic u, input logic [3:0] p);
    logic [PB-1:0] pk;
    pk = {$urandom, $urandom, $urandom, $urandom};
    pk[PB-1]     = v;
    pk[PB-2]     = u;
    pk[PB-3 -: 4] = p;
    return pk;
  endfunction

  // Advance the model by one clock using the inputs currently on the DUT pins.
  task automatic modelStep();
    logic          v;
    logic          u;
    logic [3:0]    p;
    logic [3:0]    hp;
    logic          wasEmpty;
    logic [PB-1:0] pk;
    pk = stream_in;
    v  = pk[PB-1];
    u  = pk[PB-2];
    p  = pk[PB-3 -: 4];
    if (reset_bft) begin
      holdQ.delete();
      expInPkt    = '0;
      expInWr     = '0;
      expUpdPkt   = '0;
      expUpdValid = '0;
      expResend   = 1'b0;
      expOvf      = 1'b0;
      expBad      = 1'b0;
      return;
    end
    expInWr     = '0;
    expUpdValid = '0;
    wasEmpty    = (holdQ.size() == 0);
    if (!wasEmpty) begin
      hp = holdQ[0][PB-3 -: 4];
      if (!in_full[hp[2:0]]) begin
        expInWr  = NIN'(1) << hp;
        expInPkt = holdQ.pop_front();
      end
    end
    if (v && !u) begin
      if (p >= NIN) expBad = 1'b1;
      else if (wasEmpty && !in_full[p[2:0]]) begin
        expInWr  = NIN'(1) << p;
        expInPkt = pk;
      end else if (holdQ.size() < HD) holdQ.push_back(pk);
      else expOvf = 1'b1;
    end
    if (v && u) begin
      if (p >= NOUT) expBad = 1'b1;
      else begin
        expUpdValid = NOUT'(1) << p;
        expUpdPkt   = pk;
      end
    end
    expResend = (holdQ.size() != 0);
  endtask

  task automatic applyStimulus(input logic [PB-1:0] pkt, input logic [NIN-1:0] full, input logic rst);
    stream_in = pkt;
    in_full   = full;
    reset_bft = rst;
    modelStep();
    @(posedge clk_bft);
    #1;
    checkOutput("inWrEn",    PB'(in_wr_en),     PB'(expInWr));
    checkOutput("inPacket",  in_packet,         expInPkt);
    checkOutput("updValid",  PB'(update_valid), PB'(expUpdValid));
    checkOutput("updPacket", update_packet,     expUpdPkt);
    checkOutput("resend",    PB'(resend),       PB'(expResend));
    checkOutput("overflow",  PB'(overflow_err), PB'(expOvf));
    checkOutput("badPort",   PB'(bad_port_err), PB'(expBad));
  endtask

  task automatic idle(input logic [NIN-1:0] full);
    applyStimulus(makePkt(1'b0, 1'($urandom), 4'($urandom)), full, 1'b0);
  endtask

  logic [PB-1:0] pktA;
  logic [PB-1:0] pktB;
  logic [PB-1:0] held;
  logic [PB-1:0] burst [5];
  int            density;

  initial begin
    stream_in = '0;
    in_full   = '0;
    reset_bft = 1'b1;
    applyStimulus('0, '0, 1'b1);
    applyStimulus('0, '0, 1'b1);
    checkOutput("rstWrEn", PB'(in_wr_en), '0);
    checkOutput("rstResend", PB'(resend), '0);

    // Unblocked data to port 3
    idle('0);
    pktA = makePkt(1'b1, 1'b0, 4'd3);
    applyStimulus(pktA, '0, 1'b0);
    checkOutput("unblkWrEn", PB'(in_wr_en), PB'(8'h08));
    checkOutput("unblkPkt", in_packet, pktA);
    idle('0);
    checkOutput("unblkOnce", PB'(in_wr_en), '0);
    checkOutput("unblkResend", PB'(resend), '0);

    // Block and drain, with an update bypass while two entries wait
    pktA = makePkt(1'b1, 1'b0, 4'd2);
    pktB = makePkt(1'b1, 1'b0, 4'd0);
    applyStimulus(pktA, 7'b0000100, 1'b0);
    checkOutput("blkResend", PB'(resend), PB'(1'b1));
    applyStimulus(pktB, 7'b0000100, 1'b0);
    checkOutput("blkNoB", PB'(in_wr_en), '0);
    pktA = pktA;
    held = makePkt(1'b1, 1'b1, 4'd6);
    applyStimulus(held, 7'b0000100, 1'b0);
    checkOutput("bypassUv", PB'(update_valid), PB'(8'h40));
    checkOutput("bypassPkt", update_packet, held);
    checkOutput("bypassResend", PB'(resend), PB'(1'b1));
    idle('0);
    checkOutput("drainA", in_packet, pktA);
    checkOutput("drainAWr", PB'(in_wr_en), PB'(8'h04));
    idle('0);
    checkOutput("drainB", in_packet, pktB);
    checkOutput("drainBWr", PB'(in_wr_en), PB'(8'h01));
    checkOutput("drainResend", PB'(resend), '0);

    // Invalid packet leaves outputs untouched
    held = update_packet;
    applyStimulus(makePkt(1'b0, 1'b1, 4'd2), '0, 1'b0);
    checkOutput("invUv", PB'(update_valid), '0);
    checkOutput("invHold", update_packet, held);

    // Full buffer: five packets to blocked port 1, fifth dropped
    for (int i = 0; i < 5; i++) begin
      burst[i] = makePkt(1'b1, 1'b0, 4'd1);
      applyStimulus(burst[i], 7'b0000010, 1'b0);
    end
    checkOutput("ovfSet", PB'(overflow_err), PB'(1'b1));
    for (int i = 0; i < 4; i++) begin
      idle('0);
      checkOutput("ovfOrder", in_packet, burst[i]);
      checkOutput("ovfWr", PB'(in_wr_en), PB'(8'h02));
    end
    idle('0);
    checkOutput("ovfFourOnly", PB'(in_wr_en), '0);

    // Dequeue plus arrival while full is not an overflow
    applyStimulus('0, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(makePkt(1'b1, 1'b0, 4'd1), 7'b0000010, 1'b0);
    applyStimulus(makePkt(1'b1, 1'b0, 4'd1), '0, 1'b0);
    checkOutput("fullSwapOvf", PB'(overflow_err), '0);
    checkOutput("fullSwapResend", PB'(resend), PB'(1'b1));
    for (int i = 0; i < 5; i++) idle('0);

    // Bad port stays sticky
    applyStimulus(makePkt(1'b1, 1'b0, 4'd9), '0, 1'b0);
    checkOutput("badNoWr", PB'(in_wr_en), '0);
    checkOutput("badSet", PB'(bad_port_err), PB'(1'b1));
    for (int i = 0; i < 20; i++) idle('0);
    checkOutput("badSticky", PB'(bad_port_err), PB'(1'b1));

    // Reset mid-drain with three entries queued
    for (int i = 0; i < 3; i++) applyStimulus(makePkt(1'b1, 1'b0, 4'd4), 7'b0010000, 1'b0);
    applyStimulus('0, '0, 1'b1);
    checkOutput("rstMidWr", PB'(in_wr_en), '0);
    checkOutput("rstMidResend", PB'(resend), '0);
    checkOutput("rstMidBad", PB'(bad_port_err), '0);
    for (int i = 0; i < 4; i++) begin
      idle('0);
      checkOutput("rstNoStale", PB'(in_wr_en), '0);
    end

    // Random traffic with varying backpressure
    density = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]     p;
      logic [NIN-1:0] full;
      if (c % 100 == 0) density = int'($urandom_range(0, 2));
      p = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      for (int b = 0; b < NIN; b++) begin
        full[b] = (density == 0) ? 1'b0 : (density == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      end
      applyStimulus(makePkt($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, p), full,
                    $urandom_range(0, 399) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/diverge_ctrl.md
# diverge_ctrl

Leaf-side receive controller for the BFT stream. It splits the single incoming `stream_in` into two kinds of traffic:
- data packets, written into the leaf's input-port FIFOs;
- freespace-update packets, forwarded to the leaf's output ports to return credit.

Data blocked by a full input FIFO is parked in an in-order hold buffer, and upstream is throttled with `resend` until the buffer drains. Update packets are never blocked.

## Interface
Parameters:
- PACKET_BITS, 97, packet width.
- NUM_PORT_BITS, 4, port-index field width.
- NUM_IN_PORTS, 7, input ports (data destinations).
- NUM_OUT_PORTS, 7, output ports (update destinations).
- HOLD_DEPTH, 4, hold-buffer entries (power of 2, ≥4).

Packet format:
- [PACKET_BITS-1] valid.
- [PACKET_BITS-2] is_update.
- [PACKET_BITS-3 -: NUM_PORT_BITS] port index.
- Remaining bits are opaque and are passed through unchanged.

Ports:
- clk_bft  in  1  clock; the block uses one clock only.
- reset_bft  in  1  reset, synchronous, active-high.
- stream_in  in  PACKET_BITS  incoming packet; ignored when valid=0.
- in_full  in  NUM_IN_PORTS  full flags of the input-port FIFOs.
- in_packet  out  PACKET_BITS  data packet for the input FIFOs.
- in_wr_en  out  NUM_IN_PORTS  one-hot write strobe.
- update_packet  out  PACKET_BITS  freespace-update packet.
- update_valid  out  NUM_OUT_PORTS  one-hot update strobe.
- resend  out  1  upstream hold request.
- overflow_err  out  1  sticky: a packet was dropped because the hold buffer was full.
- bad_port_err  out  1  sticky: a packet carried a port index out of range.

## Operation
- All outputs are registered. On reset, every output is 0 and the hold buffer is emptied.
- The port index of the incoming packet is p.

Update packets (valid=1, is_update=1):
- p < NUM_OUT_PORTS: next cycle `update_valid[p]`=1 and `update_packet`=stream_in.
- Update packets bypass the hold buffer entirely and are unaffected by `resend`.

Data packets (valid=1, is_update=0):
- Buffer empty and `in_full[p]`=0, both sampled in the arrival cycle: next cycle `in_wr_en[p]`=1 and `in_packet`=packet.
- Otherwise the packet is enqueued at the buffer tail. This preserves arrival order; a later packet never overtakes one already in the buffer.

Hold buffer:
- Each cycle the head is examined. If `in_full[head.p]`=0, it is dequeued and written next cycle.
- At most one data write occurs per cycle, and the head has priority over a new arrival.
- Dequeue and enqueue in the same cycle are both performed, including when the buffer is full; this is not an overflow.
- Enqueue into a full buffer with no dequeue in that cycle: the packet is dropped and `overflow_err` is set.
- The buffer is a circular FIFO with log2(HOLD_DEPTH) pointers that wrap. Occupancy is a counter of width log2(HOLD_DEPTH)+1.

resend:
- `resend` is a registered copy of (occupancy after this cycle's update ≠ 0).
- Upstream contract: while `resend`=1, upstream stops issuing new data within 2 cycles; HOLD_DEPTH≥4 absorbs that in-flight traffic.

Errors:
- p ≥ NUM_IN_PORTS (data) or p ≥ NUM_OUT_PORTS (update): the packet is dropped, no strobe is raised, and `bad_port_err` is set.
- Sticky errors clear only on reset.
- A packet with valid=0 is ignored: no strobes, and `in_packet` and `update_packet` hold their last values.

## Timing
- Latency, unblocked data or update packet: arrival cycle N, strobe in cycle N+1, held for exactly 1 cycle.
- Latency, blocked data packet: enqueued in cycle N and `resend`=1 in cycle N+1. Once `in_full[p]` falls in cycle M with the packet at the head, the write strobe appears in cycle M+1.
- resend deassertion: `resend` falls in the cycle after the last dequeue. It rises and falls once per drain and does not chatter.
- Simultaneous data and update: both strobes can be active in the same cycle.
- Reset mid-operation: the buffer is discarded, and all strobes and `resend` are 0 in the cycle after reset is sampled.

## Test plan
- Unblocked data: data packet with p=3, `in_full`=0, at cycle 10 → `in_wr_en`=0x08 at cycle 11 and only then; `in_packet` matches bit-exact; `resend` stays 0.
- Update bypass: update packet with p=6 while the buffer holds 2 entries → `update_valid`=0x40 next cycle; `resend` stays 1; buffer order unchanged.
- Block and drain: `in_full[2]`=1; send data A(p=2) then B(p=0) → `resend`=1 the cycle after A, and B is not written before A. Release `in_full[2]` at cycle M → A written at M+1, B at M+2, and `resend`=0 at M+2.
- Full buffer: hold `in_full[1]`=1 and send 5 packets to p=1 → 4 are buffered, the 5th is dropped, and `overflow_err`=1. Then release `in_full[1]` → exactly 4 writes in order. Separately, with a full buffer, one dequeue plus one arrival in the same cycle → no error.
- Bad port and invalid packet: a data packet with p=9 → no strobe and `bad_port_err`=1, still set 20 cycles later. A packet with valid=0 → no activity.
- Reset mid-drain: assert `reset_bft` while 3 entries are buffered → next cycle all outputs are 0, and no stale writes occur after reset is released.
